life_cell_engine: RTL



---
 rtl/life_cell_engine_pkg.sv | 53 +++++
 rtl/life_cell_engine_if.sv | 31 +++
 rtl/life_neighbour_count.sv | 37 +++
 rtl/life_cell_engine.sv | 118 +++++++++++
 4 files changed

// File: rtl/life_cell_engine_pkg.sv
// Shared definitions for the Game-of-Life datapath and the controlling FSM:
// the board geometry, the B3/S23 rule constants, and the strobe priority
// encoding, plus small helpers for the rule and the popcount.
package life_cell_engine_pkg;

  localparam int CELLS = 16;
  localparam int GEN_W = 8;
  localparam int IDX_W = 4;
  localparam int CNT_W = 4;
  localparam int POP_W = 5;

  // Cell index layout: idx[3:2] = row, idx[1:0] = column.
  localparam int ROW_MSB = 3;
  localparam int ROW_LSB = 2;
  localparam int COL_MSB = 1;
  localparam int COL_LSB = 0;

  // B3/S23: a dead cell with exactly BIRTH live neighbours is born; a live
  // cell with BIRTH or SURVIVE live neighbours stays alive.
  localparam logic [CNT_W-1:0] BIRTH   = 4'd3;
  localparam logic [CNT_W-1:0] SURVIVE = 4'd2;

  // Highest-priority strobe of a cycle, as both sides of the FSM see it.
  typedef enum logic [2:0] {
    STB_IDLE   = 3'd0,
    STB_LOAD   = 3'd1,
    STB_COMMIT = 3'd2,
    STB_WRITE  = 3'd3,
    STB_READ   = 3'd4
  } strobe_e;

  // load_data > writeout > write_data > read_data
  function automatic strobe_e decode_strobe(input logic load, input logic commit,
                                            input logic write, input logic read);
    if (load)        return STB_LOAD;
    else if (commit) return STB_COMMIT;
    else if (write)  return STB_WRITE;
    else if (read)   return STB_READ;
    else             return STB_IDLE;
  endfunction

  function automatic logic next_cell(input logic alive, input logic [CNT_W-1:0] cnt);
    return (cnt == BIRTH) | (alive & (cnt == SURVIVE));
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [CELLS-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < CELLS; i++) n = n + {{(POP_W-1){1'b0}}, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/life_cell_engine_if.sv
// Control/status bus between the game-control FSM (master) and the
// life_cell_engine datapath (slave).
interface life_cell_engine_if;
  import life_cell_engine_pkg::*;

  // FSM -> engine
  logic             load_data;
  logic             read_data;
  logic             write_data;
  logic             writeout;
  logic [IDX_W-1:0] cell_idx;
  logic [CELLS-1:0] data_in;

  // engine -> FSM / display
  logic [CELLS-1:0] board_out;
  logic [POP_W-1:0] alive_count;
  logic [GEN_W-1:0] gen_count;
  logic             lose_sig;
  logic             proto_err;

  modport master (
    output load_data, read_data, write_data, writeout, cell_idx, data_in,
    input  board_out, alive_count, gen_count, lose_sig, proto_err
  );

  modport slave (
    input  load_data, read_data, write_data, writeout, cell_idx, data_in,
    output board_out, alive_count, gen_count, lose_sig, proto_err
  );

endinterface

// File: rtl/life_neighbour_count.sv
// Counts the live neighbours of one cell on the 4x4 toroidal board.
// Row and column wrap with plain 2-bit arithmetic, so -1 is +3 mod 4.
module life_neighbour_count
  import life_cell_engine_pkg::*;
(
  input  logic [CELLS-1:0] board_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [CNT_W-1:0] count_o
);

  logic [1:0] row;
  logic [1:0] col;

  assign row = idx_i[ROW_MSB:ROW_LSB];
  assign col = idx_i[COL_MSB:COL_LSB];

  // Sum the 8 cells of the 3x3 window around (row, col), skipping the centre.
  always_comb begin
    logic [1:0] rr;
    logic [1:0] cc;
    // NOTE: every variable written here gets a value before any branch, so
    // no path can leave it holding its old value and infer a latch.
    rr      = '0;
    cc      = '0;
    count_o = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        if (!(dr == 1 && dc == 1)) begin
          rr      = row + 2'(dr) + 2'd3;
          cc      = col + 2'(dc) + 2'd3;
          count_o = count_o + {{(CNT_W-1){1'b0}}, board_i[{rr, cc}]};
        end
      end
    end
  end

endmodule

// File: rtl/life_cell_engine.sv
// Game-of-Life datapath driven by the game-control FSM. Holds the committed
// board and the next-generation board, evaluates B3/S23 one cell per
// read/write strobe pair, commits generations, and flags a dead or still
// board (lose_sig) and strobe misuse (proto_err).
module life_cell_engine
  import life_cell_engine_pkg::*;
(
  input  logic                clka,
  input  logic                rst,
  life_cell_engine_if.slave   bus
);

  logic [CELLS-1:0] board_q,      board_d;
  logic [CELLS-1:0] next_board_q, next_board_d;
  logic [CNT_W-1:0] nbr_cnt_q,    nbr_cnt_d;
  logic [IDX_W-1:0] nbr_idx_q,    nbr_idx_d;
  logic             nbr_valid_q,  nbr_valid_d;
  logic [GEN_W-1:0] gen_q,        gen_d;
  logic [POP_W-1:0] alive_q,      alive_d;
  logic             lose_q,       lose_d;
  logic             perr_q,       perr_d;

  strobe_e          strobe;
  logic [CNT_W-1:0] nbr_live;
  logic             write_ok;

  // Neighbours always come from the committed board, so cells written
  // earlier in a sweep do not disturb later reads.
  life_neighbour_count u_nbr (
    .board_i (board_q),
    .idx_i   (bus.cell_idx),
    .count_o (nbr_live)
  );

  assign write_ok = nbr_valid_q && (bus.cell_idx == nbr_idx_q);

  // Resolve strobe priority and compute every next-state value.
  always_comb begin
    strobe       = decode_strobe(bus.load_data, bus.writeout, bus.write_data, bus.read_data);
    board_d      = board_q;
    next_board_d = next_board_q;
    nbr_cnt_d    = nbr_cnt_q;
    nbr_idx_d    = nbr_idx_q;
    nbr_valid_d  = nbr_valid_q;
    gen_d        = gen_q;
    lose_d       = lose_q;
    perr_d       = perr_q;
    alive_d      = popcount(board_q);

    case (strobe)
      STB_LOAD: begin
        board_d      = bus.data_in;
        next_board_d = bus.data_in;
        gen_d        = '0;
        lose_d       = 1'b0;
        perr_d       = 1'b0;
        nbr_valid_d  = 1'b0;
      end
      STB_COMMIT: begin
        board_d = next_board_q;
        if (gen_q != '1) gen_d = gen_q + 1'b1;
        if (next_board_q == '0 || next_board_q == board_q) lose_d = 1'b1;
      end
      STB_WRITE: begin
        nbr_valid_d = 1'b0;
        if (write_ok) begin
          next_board_d[bus.cell_idx] = next_cell(board_q[bus.cell_idx], nbr_cnt_q);
        end else begin
          perr_d = 1'b1;
        end
        // A read in the same cycle is dropped and counts as misuse.
        if (bus.read_data) perr_d = 1'b1;
      end
      STB_READ: begin
        nbr_cnt_d   = nbr_live;
        nbr_idx_d   = bus.cell_idx;
        nbr_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State registers; reset aborts any sweep with no partial commit.
  always_ff @(posedge clka or posedge rst) begin
    // NOTE: both boards are ordinary flops, so they are reset along with
    // everything else; a reset in mid-sweep leaves nothing stale behind.
    if (rst) begin
      board_q      <= '0;
      next_board_q <= '0;
      nbr_cnt_q    <= '0;
      nbr_idx_q    <= '0;
      nbr_valid_q  <= 1'b0;
      gen_q        <= '0;
      alive_q      <= '0;
      lose_q       <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      board_q      <= board_d;
      next_board_q <= next_board_d;
      nbr_cnt_q    <= nbr_cnt_d;
      nbr_idx_q    <= nbr_idx_d;
      nbr_valid_q  <= nbr_valid_d;
      gen_q        <= gen_d;
      alive_q      <= alive_d;
      lose_q       <= lose_d;
      perr_q       <= perr_d;
    end
  end

  assign bus.board_out   = board_q;
  assign bus.alive_count = alive_q;
  assign bus.gen_count   = gen_q;
  assign bus.lose_sig    = lose_q;
  assign bus.proto_err   = perr_q;

endmodule
